// File: rtl/cls_pkg.sv
// ---------------------------------------------------------------------------
// cls_pkg
// Shared definitions for the lockstep response distributor.
//   CORE_MS / CORE_SL1 / CORE_SL2 : bit positions of each core inside the
//                                   replicated {ms,sl1,sl2} output vectors.
//   NUM_CORES                     : number of cores fed by the distributor.
//   DEF_MAX_DELAY                 : default depth of the slave delay lines.
//   resp_t                        : one response-channel beat (gnt, rvalid, rdata).
// ---------------------------------------------------------------------------
package cls_pkg;
    localparam int CORE_MS       = 2;
    localparam int CORE_SL1      = 1;
    localparam int CORE_SL2      = 0;
    localparam int NUM_CORES     = 3;
    localparam int DEF_MAX_DELAY = 4;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } resp_t;

    localparam resp_t RESP_IDLE = '0;
endpackage

// File: rtl/cls_resp_dist_if.sv
// ---------------------------------------------------------------------------
// cls_resp_dist_if
// Memory-side response stream plus the replicated per-core copies.
//   instr_/data_req_ms               : voted master requests seen by memory
//   instr_/data_gnt_i, _rvalid_i, _rdata_i : single memory response stream
//   instr_/data_gnt_o, _rvalid_o     : per-core copies, {ms,sl1,sl2}
//   instr_/data_rdata_o              : per-core read data, {ms,sl1,sl2}
// Modports: master = memory/system side, slave = the distributor.
// ---------------------------------------------------------------------------
interface cls_resp_dist_if;
    import cls_pkg::*;

    logic                      instr_req_ms;
    logic                      data_req_ms;
    logic                      instr_gnt_i;
    logic                      instr_rvalid_i;
    logic [31:0]               instr_rdata_i;
    logic                      data_gnt_i;
    logic                      data_rvalid_i;
    logic [31:0]               data_rdata_i;
    logic [NUM_CORES-1:0]      instr_gnt_o;
    logic [NUM_CORES-1:0]      instr_rvalid_o;
    logic [NUM_CORES*32-1:0]   instr_rdata_o;
    logic [NUM_CORES-1:0]      data_gnt_o;
    logic [NUM_CORES-1:0]      data_rvalid_o;
    logic [NUM_CORES*32-1:0]   data_rdata_o;

    modport master (
        output instr_req_ms, data_req_ms,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
        output data_gnt_i, data_rvalid_i, data_rdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o
    );

    modport slave (
        input  instr_req_ms, data_req_ms,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
        input  data_gnt_i, data_rvalid_i, data_rdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o
    );
endinterface

// File: rtl/cls_delay_line.sv
// ---------------------------------------------------------------------------
// cls_delay_line
// Free-running shift register of DEPTH response beats with a fixed tap.
//   clk, rst : clock, synchronous active-high reset
//   clear    : drop every stage on the next edge (flush)
//   din      : beat entering the line (already registered by the caller)
//   dout     : din delayed by DELAY cycles; DELAY=0 passes din straight through
// ---------------------------------------------------------------------------
module cls_delay_line
    import cls_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_DELAY,
    parameter int DELAY = 0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clear,
    input  resp_t din,
    output resp_t dout
);

    resp_t dly_p [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < DEPTH; i++) dly_p[i] <= RESP_IDLE;
        end else begin
            dly_p[0] <= din;
            for (int i = 1; i < DEPTH; i++) dly_p[i] <= dly_p[i-1];
        end
    end

    if (DELAY == 0) begin : g_pass
        assign dout = din;
    end else begin : g_tap
        assign dout = dly_p[DELAY-1];
    end

endmodule

// File: rtl/cls_resp_dist.sv
// ---------------------------------------------------------------------------
// cls_resp_dist
// Replicates the memory response stream to the master core and two slave
// cores, with optional fixed skew on each slave copy, and tracks in-flight
// transactions per channel to flag protocol violations.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop all in-flight state (proto_err is kept)
//   bus               : memory response stream in, {ms,sl1,sl2} copies out
//   instr_outstanding : instruction in-flight count
//   data_outstanding  : data in-flight count
//   proto_err         : sticky protocol-violation flag, cleared only by rst
// ---------------------------------------------------------------------------
module cls_resp_dist
    import cls_pkg::*;
#(
    parameter int SL1_DELAY       = 0,
    parameter int SL2_DELAY       = 0,
    parameter int MAX_DELAY       = DEF_MAX_DELAY,
    parameter int MAX_OUTSTANDING = 3,
    parameter int CNT_W           = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    cls_resp_dist_if.slave   bus,
    output logic [CNT_W-1:0] instr_outstanding,
    output logic [CNT_W-1:0] data_outstanding,
    output logic             proto_err
);

    if (SL1_DELAY > MAX_DELAY || SL2_DELAY > MAX_DELAY) begin : g_bad_delay
        $error("cls_resp_dist: slave delay exceeds MAX_DELAY");
    end
    if ((2 ** CNT_W) <= MAX_OUTSTANDING) begin : g_bad_cnt
        $error("cls_resp_dist: CNT_W too narrow for MAX_OUTSTANDING");
    end

    // Returns {error, next_count}. A simultaneous increment and decrement
    // cancel, so neither the saturation nor the underflow check applies.
    function automatic logic [CNT_W:0] track(input logic [CNT_W-1:0] cnt,
                                             input logic req, input logic gnt,
                                             input logic rvalid);
        logic             inc;
        logic             err;
        logic [CNT_W-1:0] nxt;
        inc = req & gnt;
        err = gnt & ~req;
        nxt = cnt;
        if (inc && !rvalid) begin
            if (cnt == CNT_W'(MAX_OUTSTANDING)) err = 1'b1;
            else                                 nxt = cnt + 1'b1;
        end else if (rvalid && !inc) begin
            if (cnt == '0) err = 1'b1;
            else           nxt = cnt - 1'b1;
        end
        return {err, nxt};
    endfunction

    // Stage p0: master copy, one register after the memory interface.
    resp_t instr_ms_p0, data_ms_p0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr_ms_p0 <= RESP_IDLE;
            data_ms_p0  <= RESP_IDLE;
        end else begin
            instr_ms_p0 <= '{gnt: bus.instr_gnt_i, rvalid: bus.instr_rvalid_i,
                             rdata: bus.instr_rdata_i};
            data_ms_p0  <= '{gnt: bus.data_gnt_i, rvalid: bus.data_rvalid_i,
                             rdata: bus.data_rdata_i};
        end
    end

    // Slave copies: the p0 beat skewed by a fixed number of cycles.
    resp_t instr_sl1, instr_sl2, data_sl1, data_sl2;

    cls_delay_line #(.DEPTH(MAX_DELAY), .DELAY(SL1_DELAY)) u_instr_sl1 (
        .clk(clk), .rst(rst), .clear(flush), .din(instr_ms_p0), .dout(instr_sl1));
    cls_delay_line #(.DEPTH(MAX_DELAY), .DELAY(SL2_DELAY)) u_instr_sl2 (
        .clk(clk), .rst(rst), .clear(flush), .din(instr_ms_p0), .dout(instr_sl2));
    cls_delay_line #(.DEPTH(MAX_DELAY), .DELAY(SL1_DELAY)) u_data_sl1 (
        .clk(clk), .rst(rst), .clear(flush), .din(data_ms_p0), .dout(data_sl1));
    cls_delay_line #(.DEPTH(MAX_DELAY), .DELAY(SL2_DELAY)) u_data_sl2 (
        .clk(clk), .rst(rst), .clear(flush), .din(data_ms_p0), .dout(data_sl2));

    assign bus.instr_gnt_o    = {instr_ms_p0.gnt,    instr_sl1.gnt,    instr_sl2.gnt};
    assign bus.instr_rvalid_o = {instr_ms_p0.rvalid, instr_sl1.rvalid, instr_sl2.rvalid};
    assign bus.instr_rdata_o  = {instr_ms_p0.rdata,  instr_sl1.rdata,  instr_sl2.rdata};
    assign bus.data_gnt_o     = {data_ms_p0.gnt,     data_sl1.gnt,     data_sl2.gnt};
    assign bus.data_rvalid_o  = {data_ms_p0.rvalid,  data_sl1.rvalid,  data_sl2.rvalid};
    assign bus.data_rdata_o   = {data_ms_p0.rdata,   data_sl1.rdata,   data_sl2.rdata};

    // Outstanding tracking and sticky error flag.
    logic [CNT_W:0] instr_trk, data_trk;

    assign instr_trk = track(instr_outstanding, bus.instr_req_ms,
                             bus.instr_gnt_i, bus.instr_rvalid_i);
    assign data_trk  = track(data_outstanding, bus.data_req_ms,
                             bus.data_gnt_i, bus.data_rvalid_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_outstanding <= '0;
            data_outstanding  <= '0;
            proto_err         <= 1'b0;
        end else if (flush) begin
            // Inputs during flush are discarded without error checking.
            instr_outstanding <= '0;
            data_outstanding  <= '0;
        end else begin
            instr_outstanding <= instr_trk[CNT_W-1:0];
            data_outstanding  <= data_trk[CNT_W-1:0];
            proto_err         <= proto_err | instr_trk[CNT_W] | data_trk[CNT_W];
        end
    end

endmodule

// File: tb/tb_cls_resp_dist.sv
// Two distributors share one stimulus stream: dut_a with no skew, dut_b with
// sl1 delayed 1 cycle and sl2 delayed 3 cycles. Response expectations go into
// a scoreboard queue; a negedge monitor pops one entry per asserted output bit.
module tb_cls_resp_dist;
    import cls_pkg::*;

    localparam int GNT = 0, RV = 1;
    localparam int INS = 0, DAT = 1;

    typedef struct {
        int          dut;
        int          ch;
        int          kind;
        int          core;
        int          at;
        logic [31:0] data;
    } exp_t;

    logic clk, rst, flush;
    logic instr_req, data_req, instr_gnt, instr_rvalid, data_gnt, data_rvalid;
    logic [31:0] instr_rdata, data_rdata;
    logic [1:0] ia_out, da_out, ib_out, db_out;
    logic pa_err, pb_err;

    int   cyc;
    int   total, bad;
    bit   mon_en;
    int   mon_idx;
    logic [31:0] mon_dat;
    exp_t sb[$];

    cls_resp_dist_if ifa ();
    cls_resp_dist_if ifb ();

    assign ifa.instr_req_ms = instr_req;    assign ifb.instr_req_ms = instr_req;
    assign ifa.data_req_ms  = data_req;     assign ifb.data_req_ms  = data_req;
    assign ifa.instr_gnt_i  = instr_gnt;    assign ifb.instr_gnt_i  = instr_gnt;
    assign ifa.instr_rvalid_i = instr_rvalid; assign ifb.instr_rvalid_i = instr_rvalid;
    assign ifa.instr_rdata_i  = instr_rdata;  assign ifb.instr_rdata_i  = instr_rdata;
    assign ifa.data_gnt_i   = data_gnt;     assign ifb.data_gnt_i   = data_gnt;
    assign ifa.data_rvalid_i = data_rvalid; assign ifb.data_rvalid_i = data_rvalid;
    assign ifa.data_rdata_i = data_rdata;   assign ifb.data_rdata_i = data_rdata;

    cls_resp_dist #(.SL1_DELAY(0), .SL2_DELAY(0), .MAX_DELAY(4),
                    .MAX_OUTSTANDING(3), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .bus(ifa),
        .instr_outstanding(ia_out), .data_outstanding(da_out), .proto_err(pa_err));

    cls_resp_dist #(.SL1_DELAY(1), .SL2_DELAY(3), .MAX_DELAY(4),
                    .MAX_OUTSTANDING(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .bus(ifb),
        .instr_outstanding(ib_out), .data_outstanding(db_out), .proto_err(pb_err));

    // Monitor view indexed [dut][channel][kind] and [dut][channel].
    logic [2:0]  mv [2][2][2];
    logic [95:0] md [2][2];
    assign mv[0][0][0] = ifa.instr_gnt_o;  assign mv[0][0][1] = ifa.instr_rvalid_o;
    assign mv[0][1][0] = ifa.data_gnt_o;   assign mv[0][1][1] = ifa.data_rvalid_o;
    assign mv[1][0][0] = ifb.instr_gnt_o;  assign mv[1][0][1] = ifb.instr_rvalid_o;
    assign mv[1][1][0] = ifb.data_gnt_o;   assign mv[1][1][1] = ifb.data_rvalid_o;
    assign md[0][0] = ifa.instr_rdata_o;   assign md[0][1] = ifa.data_rdata_o;
    assign md[1][0] = ifb.instr_rdata_o;   assign md[1][1] = ifb.data_rdata_o;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dly(input int u, input int k);
        if (k == CORE_MS || u == 0) return 0;
        return (k == CORE_SL1) ? 1 : 3;
    endfunction

    // Expect a beat presented in cycle c on every core of both duts at
    // c+1+delay, unless flush is asserted in any cycle c..c+delay.
    task automatic push(input int kind, input int ch, input int c,
                        input logic [31:0] d, input int fl);
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 3; k++) begin
                int dl;
                dl = dly(u, k);
                if (!(fl >= c && fl <= c + dl))
                    sb.push_back('{u, ch, kind, k, c + 1 + dl, d});
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_st(input string nm, input int ic, input int dc, input int pe);
        chk({nm, "_a_iout"}, 32'(ia_out), 32'(ic));
        chk({nm, "_a_dout"}, 32'(da_out), 32'(dc));
        chk({nm, "_a_err"},  32'(pa_err), 32'(pe));
        chk({nm, "_b_iout"}, 32'(ib_out), 32'(ic));
        chk({nm, "_b_dout"}, 32'(db_out), 32'(dc));
        chk({nm, "_b_err"},  32'(pb_err), 32'(pe));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_a_ctl"}, 32'({ifa.instr_gnt_o, ifa.instr_rvalid_o,
                                 ifa.data_gnt_o, ifa.data_rvalid_o}), 32'd0);
        chk({nm, "_a_dat"}, 32'(|{ifa.instr_rdata_o, ifa.data_rdata_o}), 32'd0);
        chk({nm, "_b_ctl"}, 32'({ifb.instr_gnt_o, ifb.instr_rvalid_o,
                                 ifb.data_gnt_o, ifb.data_rvalid_o}), 32'd0);
        chk({nm, "_b_dat"}, 32'(|{ifb.instr_rdata_o, ifb.data_rdata_o}), 32'd0);
    endtask

    task automatic clr_in();
        instr_req = 0; instr_gnt = 0; instr_rvalid = 0; instr_rdata = '0;
        data_req  = 0; data_gnt  = 0; data_rvalid  = 0; data_rdata  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int u = 0; u < 2; u++)
            for (int ch = 0; ch < 2; ch++)
            for (int kd = 0; kd < 2; kd++)
            for (int k = 0; k < 3; k++) begin
                if (mv[u][ch][kd][k]) begin
                    mon_idx = -1;
                    for (int i = 0; i < sb.size(); i++)
                        if (mon_idx < 0 && sb[i].dut == u && sb[i].ch == ch &&
                            sb[i].kind == kd && sb[i].core == k)
                            mon_idx = i;
                    mon_dat = md[u][ch][k*32 +: 32];
                    total++;
                    if (mon_idx < 0) begin
                        bad++;
                        $display("FAIL unexpected d%0d ch%0d kind%0d core%0d: cyc=%0d data=%h want none",
                                 u, ch, kd, k, cyc, mon_dat);
                    end else begin
                        if (sb[mon_idx].at != cyc ||
                            (kd == RV && sb[mon_idx].data !== mon_dat)) begin
                            bad++;
                            $display("FAIL resp d%0d ch%0d kind%0d core%0d: got cyc=%0d data=%h want cyc=%0d data=%h",
                                     u, ch, kd, k, cyc, mon_dat, sb[mon_idx].at, sb[mon_idx].data);
                        end
                        sb.delete(mon_idx);
                    end
                end
            end
        end
    end

    initial begin
        int f0;
        cyc = 0; total = 0; bad = 0; mon_en = 0;
        rst = 1; flush = 0;
        clr_in();
        tick(); tick();
        rst = 0;
        @(negedge clk);
        chk_st("reset", 0, 0, 0);
        chk_zero("reset");
        mon_en = 1;

        // Zero-delay instruction transaction.
        tick(); instr_req = 1; instr_gnt = 1; push(GNT, INS, cyc, '0, -1);
        tick(); clr_in(); @(negedge clk); chk_st("t1_one", 1, 0, 0);
        tick(); instr_rvalid = 1; instr_rdata = 32'hDEADBEEF;
        push(RV, INS, cyc, 32'hDEADBEEF, -1);
        tick(); clr_in(); @(negedge clk); chk_st("t1_zero", 0, 0, 0);

        // Skewed data transaction.
        tick(); data_req = 1; data_gnt = 1; push(GNT, DAT, cyc, '0, -1);
        tick(); clr_in(); @(negedge clk); chk_st("t2_one", 0, 1, 0);
        tick(); tick(); data_rvalid = 1; data_rdata = 32'h12345678;
        push(RV, DAT, cyc, 32'h12345678, -1);
        tick(); clr_in();
        repeat (4) tick();
        @(negedge clk); chk_st("t2_zero", 0, 0, 0);

        // Saturation: four grants, no responses.
        for (int i = 0; i < 4; i++) begin
            tick(); clr_in(); instr_req = 1; instr_gnt = 1;
            push(GNT, INS, cyc, '0, -1);
            if (i == 3) begin
                @(negedge clk); chk_st("t3_full", 3, 0, 0);
            end
        end
        tick(); clr_in(); @(negedge clk); chk_st("t3_sat", 3, 0, 1);
        tick(); instr_rvalid = 1; instr_rdata = 32'h0000A5A5;
        push(RV, INS, cyc, 32'h0000A5A5, -1);
        tick(); clr_in(); @(negedge clk); chk_st("t4_two", 2, 0, 1);

        // Reset mid-operation, then a fresh transaction.
        repeat (4) tick();
        rst = 1;
        tick(); rst = 0; @(negedge clk);
        chk_st("t4_rst", 0, 0, 0);
        chk_zero("t4_rst");
        tick(); data_req = 1; data_gnt = 1; push(GNT, DAT, cyc, '0, -1);
        tick(); clr_in(); @(negedge clk); chk_st("t4_fresh1", 0, 1, 0);
        tick(); data_rvalid = 1; data_rdata = 32'h600DF00D;
        push(RV, DAT, cyc, 32'h600DF00D, -1);
        tick(); clr_in(); @(negedge clk); chk_st("t4_fresh0", 0, 0, 0);
        repeat (4) tick();

        // Spurious response with nothing outstanding.
        tick(); data_rvalid = 1; data_rdata = 32'h5A5A0001;
        push(RV, DAT, cyc, 32'h5A5A0001, -1);
        tick(); clr_in(); @(negedge clk); chk_st("t5_spur", 0, 0, 1);
        repeat (4) tick();

        // Flush two cycles after the first grant, one after the rvalid.
        tick(); clr_in(); instr_req = 1; instr_gnt = 1; f0 = cyc;
        push(GNT, INS, cyc, '0, f0 + 2);
        tick(); instr_req = 1; instr_gnt = 1; instr_rvalid = 1; instr_rdata = 32'hCAFE0001;
        push(GNT, INS, cyc, '0, f0 + 2);
        push(RV, INS, cyc, 32'hCAFE0001, f0 + 2);
        tick(); clr_in(); flush = 1; data_req = 1; data_gnt = 1; data_rvalid = 1;
        data_rdata = 32'h0BAD0BAD;
        tick(); clr_in(); flush = 0; @(negedge clk);
        chk_st("t6_flush", 0, 0, 1);
        chk_zero("t6_flush");
        repeat (6) tick();
        @(negedge clk); chk_st("t6_end", 0, 0, 1);

        mon_en = 0;
        foreach (sb[i]) begin
            total++;
            bad++;
            $display("FAIL missing d%0d ch%0d kind%0d core%0d: got none want cyc=%0d data=%h",
                     sb[i].dut, sb[i].ch, sb[i].kind, sb[i].core, sb[i].at, sb[i].data);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
